// File: rtl/top_module_and_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the AND-reduction tree.
// The helpers size and place each tree level inside one flat node vector.
package top_module_and_reduce_pkg;

  // Number of operand buses folded into the reduction.
  localparam int BUS_COUNT = 8;

  // Number of nodes at a given tree level (level 0 is the raw input bits).
  function automatic int level_width(input int total, input int radix, input int level);
    int n;
    n = total;
    for (int i = 0; i < level; i++) begin
      n = (n + radix - 1) / radix;
    end
    return n;
  endfunction

  // Levels of radix-input nodes needed to fold 'total' bits into one bit.
  function automatic int tree_depth(input int total, input int radix);
    int n;
    int d;
    n = total;
    d = 0;
    while (n > 1) begin
      n = (n + radix - 1) / radix;
      d = d + 1;
    end
    return d;
  endfunction

  // Bit offset of a level inside the flat vector: sum of widths of all lower levels.
  function automatic int level_offset(input int total, input int radix, input int level);
    int off;
    off = 0;
    for (int i = 0; i < level; i++) begin
      off = off + level_width(total, radix, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/top_module_and_reduce_and_tree_node.sv
// One node of the reduction tree: an N-input AND gate.
module and_tree_node #(
  parameter int N = 2
) (
  input  logic [N-1:0] operands,
  output logic         result
);

  assign result = &operands;

endmodule

// File: rtl/top_module_and_reduce.sv
// Wide AND-reduction of eight WIDTH-bit buses into one truth bit, presented
// zero-extended on q (combinational) and q_reg (one clock later).
// The tree radix only changes depth and shape, never the result.
module top_module_and_reduce
  import top_module_and_reduce_pkg::*;
#(
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_reg
);

  localparam int TOTAL_BITS = BUS_COUNT * WIDTH;
  localparam int DEPTH      = tree_depth(TOTAL_BITS, Port_Num);
  // Levels 0..DEPTH packed end to end; the single root node is the top bit.
  localparam int TREE_BITS  = level_offset(TOTAL_BITS, Port_Num, DEPTH + 1);

  logic [TREE_BITS-1:0] tree_s;
  logic                 root_s;
  logic [WIDTH-1:0]     q_reg_r;

  // Level 0: every operand bit. Ordering does not matter for an AND.
  assign tree_s[TOTAL_BITS-1:0] = {h, g, f, e, d, c, b, a};

  // Build the tree level by level; inputs past the end of a level are tied to 1
  // so partially populated nodes stay neutral.
  for (genvar l = 1; l <= DEPTH; l++) begin : g_level
    localparam int IN_W    = level_width(TOTAL_BITS, Port_Num, l - 1);
    localparam int IN_OFF  = level_offset(TOTAL_BITS, Port_Num, l - 1);
    localparam int OUT_W   = level_width(TOTAL_BITS, Port_Num, l);
    localparam int OUT_OFF = level_offset(TOTAL_BITS, Port_Num, l);

    for (genvar j = 0; j < OUT_W; j++) begin : g_node
      logic [Port_Num-1:0] ops_s;

      for (genvar k = 0; k < Port_Num; k++) begin : g_in
        if (j * Port_Num + k < IN_W) begin : g_used
          assign ops_s[k] = tree_s[IN_OFF + j * Port_Num + k];
        end else begin : g_tie
          assign ops_s[k] = 1'b1;
        end
      end

      and_tree_node #(
        .N (Port_Num)
      ) u_node (
        .operands (ops_s),
        .result   (tree_s[OUT_OFF + j])
      );
    end
  end

  assign root_s = tree_s[TREE_BITS-1];

  // Zero-extend the truth bit onto the result bus; no padding when WIDTH is 1.
  if (WIDTH == 1) begin : g_narrow
    assign q = root_s;
  end else begin : g_wide
    assign q = {{(WIDTH-1){1'b0}}, root_s};
  end

  // Registered copy of q for pipelined consumers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg_r <= {WIDTH{1'b0}};
    end else begin
      q_reg_r <= q;
    end
  end

  assign q_reg = q_reg_r;

endmodule

// File: tb/tb_top_module_and_reduce.sv
// Self-checking bench for top_module_and_reduce: WIDTH=7 at radix 2, 3 and 8,
// plus WIDTH=1 at radix 3 and 8. Registered results go through a scoreboard.
module tb_top_module_and_reduce;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] a, b, c, d, e, f, g, h;
  logic [6:0] q, q_reg, q3, q3_reg, q8, q8_reg;
  logic       a1, b1, c1, d1, e1, f1, g1, h1;
  logic       q31, q31_reg, q81, q81_reg;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [6:0] sb_q[$];

  always #5 clk = ~clk;

  top_module_and_reduce #(.Port_Num(2), .WIDTH(7)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .q(q), .q_reg(q_reg));

  top_module_and_reduce #(.Port_Num(3), .WIDTH(7)) dut_p3 (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .q(q3), .q_reg(q3_reg));

  top_module_and_reduce #(.Port_Num(8), .WIDTH(7)) dut_p8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .q(q8), .q_reg(q8_reg));

  top_module_and_reduce #(.Port_Num(3), .WIDTH(1)) dut_p3_w1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .q(q31), .q_reg(q31_reg));

  top_module_and_reduce #(.Port_Num(8), .WIDTH(1)) dut_p8_w1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .q(q81), .q_reg(q81_reg));

  // Reference: truth bit is 1 only when every bus is all ones.
  function automatic logic [6:0] exp7();
    if (a == 7'h7F && b == 7'h7F && c == 7'h7F && d == 7'h7F &&
        e == 7'h7F && f == 7'h7F && g == 7'h7F && h == 7'h7F)
      return 7'h01;
    else
      return 7'h00;
  endfunction

  function automatic logic [6:0] exp1();
    if (a1 == 1'b1 && b1 == 1'b1 && c1 == 1'b1 && d1 == 1'b1 &&
        e1 == 1'b1 && f1 == 1'b1 && g1 == 1'b1 && h1 == 1'b1)
      return 7'h01;
    else
      return 7'h00;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic set_all(input logic [6:0] v);
    a = v; b = v; c = v; d = v; e = v; f = v; g = v; h = v;
  endtask

  task automatic set_all1(input logic v);
    a1 = v; b1 = v; c1 = v; d1 = v; e1 = v; f1 = v; g1 = v; h1 = v;
  endtask

  // Let inputs settle, then check combinational q on all WIDTH=7 instances.
  task automatic check_comb7(input string tag);
    logic [6:0] ev;
    #1;
    ev = exp7();
    check({tag, "_q_p2"}, q,  ev);
    check({tag, "_q_p3"}, q3, ev);
    check({tag, "_q_p8"}, q8, ev);
  endtask

  task automatic check_comb1(input string tag);
    logic [6:0] ev;
    #1;
    ev = exp1();
    check({tag, "_q_p3w1"}, {6'b000000, q31}, ev);
    check({tag, "_q_p8w1"}, {6'b000000, q81}, ev);
  endtask

  // One clock: push the expected q_reg for this edge, then pop and compare after it.
  task automatic tick(input string tag);
    logic [6:0] ev;
    sb_q.push_back(reset ? 7'h00 : exp7());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb_empty: observed empty scoreboard expected one entry", tag);
    end else begin
      ev = sb_q.pop_front();
      check({tag, "_qreg_p2"}, q_reg,  ev);
      check({tag, "_qreg_p3"}, q3_reg, ev);
      check({tag, "_qreg_p8"}, q8_reg, ev);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_all(7'h7F);
    set_all1(1'b1);

    // Reset state: q_reg cleared while q still follows the all-ones inputs.
    tick("rst0");
    tick("rst1");
    check_comb7("rst_comb");
    check("rst_qreg_p3w1", {6'b000000, q31_reg}, 7'h00);

    // 1. All ones.
    reset = 1'b0;
    set_all(7'h7F);
    check_comb7("s1_ones");
    tick("s1_ones");

    // 2. MSB of last bus cleared.
    h = 7'h3F;
    check_comb7("s2_hmsb");
    tick("s2_hmsb");

    // 3. LSB of first bus cleared.
    h = 7'h7F;
    a = 7'h7E;
    check_comb7("s3_alsb");
    tick("s3_alsb");

    // 4. Random vectors, 1 ns apart, no clock edge needed.
    for (int i = 0; i < 10; i++) begin
      a = 7'($urandom_range(127, 0)); b = 7'($urandom_range(127, 0));
      c = 7'($urandom_range(127, 0)); d = 7'($urandom_range(127, 0));
      e = 7'($urandom_range(127, 0)); f = 7'($urandom_range(127, 0));
      g = 7'($urandom_range(127, 0)); h = 7'($urandom_range(127, 0));
      check_comb7("s4_rand");
    end

    // X propagates through AND where nothing else decides the result.
    set_all(7'h7F);
    a = 7'b111x111;
    #1;
    check("x_prop", q, 7'b000000x);
    // A known 0 anywhere dominates the X.
    e = 7'h7B;
    #1;
    check("x_dom", q, 7'h00);

    // 5. Reset mid-operation with all-ones inputs held.
    set_all(7'h7F);
    tick("s5_load");
    reset = 1'b1;
    tick("s5_rst0");
    check_comb7("s5_rst0_comb");
    tick("s5_rst1");
    check_comb7("s5_rst1_comb");
    reset = 1'b0;
    tick("s5_rel");

    // 6. WIDTH=1 at radix 3 and 8.
    set_all1(1'b1);
    check_comb1("s6_ones");
    tick("s6_ones");
    check("s6_ones_qreg_p3w1", {6'b000000, q31_reg}, 7'h01);
    check("s6_ones_qreg_p8w1", {6'b000000, q81_reg}, 7'h01);
    h1 = 1'b0;
    check_comb1("s6_h0");
    a1 = 1'b0;
    h1 = 1'b1;
    check_comb1("s6_a0");
    tick("s6_a0");
    check("s6_a0_qreg_p8w1", {6'b000000, q81_reg}, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
